// File: rtl/wdog_rstmon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wdog_rstmon_pkg
// Brief    : Shared state type and default sizing for the watchdog reset monitor
// Revision : 1.0
// ============================================================================
package wdog_rstmon_pkg;

    localparam int c_min_pulse = 4;
    localparam int c_cnt_w     = 8;
    localparam int c_width_w   = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rstmon_sync2.sv
`default_nettype none
// ============================================================================
// Module   : rstmon_sync2
// Brief    : Multi-flop level synchronizer, all stages reset to 1 (deasserted);
//            exposes every stage after the first
// Revision : 1.0
// ============================================================================
module rstmon_sync2
    import wdog_rstmon_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              d,
    output logic [STAGES-1:1] q
);

    logic [STAGES-1:0] r_stage;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_stage <= '1;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], d};
        end
    end

    // Stage 0 may be metastable, so only later stages leave the module.
    assign q = r_stage[STAGES-1:1];

endmodule
`default_nettype wire

// File: rtl/wdog_reset_monitor.sv
`default_nettype none
// ============================================================================
// Module   : wdog_reset_monitor
// Brief    : Synchronizes the watchdog reset line, measures low-pulse width,
//            counts events and flags short pulses. Optional macro
//            WDOG_RSTMON_DEGLITCH_EN adds a 2-sample agreement filter.
// Revision : 1.0
// ============================================================================
module wdog_reset_monitor
    import wdog_rstmon_pkg::*;
#(
    parameter int MIN_PULSE = c_min_pulse,
    parameter int CNT_W     = c_cnt_w,
    parameter int WIDTH_W   = c_width_w
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               wdogresn,
    input  logic               clr,
    output logic               in_reset,
    output logic               rst_done,
    output logic [CNT_W-1:0]   event_cnt,
    output logic [WIDTH_W-1:0] last_width,
    output logic               short_pulse
);

    localparam logic [WIDTH_W-1:0] c_min_w = WIDTH_W'(MIN_PULSE);

    logic w_lvl;

`ifdef WDOG_RSTMON_DEGLITCH_EN
    logic [2:1] w_sync;
    logic       r_hold;

    rstmon_sync2 #(.STAGES(3)) u_sync (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (wdogresn),
        .q       (w_sync)
    );

    // Level only moves once two consecutive samples agree.
    assign w_lvl = (w_sync[1] == w_sync[2]) ? w_sync[2] : r_hold;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_hold <= 1'b1;
        end else begin
            r_hold <= w_lvl;
        end
    end
`else
    logic [1:1] w_sync;

    rstmon_sync2 #(.STAGES(2)) u_sync (
        .pclk    (pclk),
        .presetn (presetn),
        .d       (wdogresn),
        .q       (w_sync)
    );

    assign w_lvl = w_sync[1];
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_cont;
    logic               w_done;
    logic               w_short;
    logic [WIDTH_W-1:0] r_width;
    logic [WIDTH_W-1:0] r_last;
    logic [CNT_W-1:0]   r_evt;
    logic               r_done;
    logic               r_short;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_cont      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_lvl) begin
                    w_state_nxt = ACTIVE;
                    w_start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_lvl) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end else begin
                    w_cont = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_short = (r_width < c_min_w);

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_width <= '0;
            r_last  <= '0;
            r_evt   <= '0;
            r_done  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            r_done <= w_done;
            if (w_start) begin
                r_width <= WIDTH_W'(1);
            end else if (w_cont && !(&r_width)) begin
                r_width <= r_width + WIDTH_W'(1);
            end
            // A completing event takes priority over a simultaneous clear.
            if (w_done) begin
                r_last  <= r_width;
                r_evt   <= clr ? CNT_W'(1) : ((&r_evt) ? r_evt : r_evt + CNT_W'(1));
                r_short <= (clr ? 1'b0 : r_short) | w_short;
            end else if (clr) begin
                r_evt   <= '0;
                r_short <= 1'b0;
            end
        end
    end

    assign in_reset    = (r_state == ACTIVE);
    assign rst_done    = r_done;
    assign event_cnt   = r_evt;
    assign last_width  = r_last;
    assign short_pulse = r_short;

endmodule
`default_nettype wire
